// File: rtl/fetch_pc_unit.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_pc_unit
//  Purpose  : Instruction-fetch front end. Owns the program counter, drives
//             the word address into a 1-cycle-latency instruction memory,
//             pairs each returned word with its PC and a valid bit, keeps the
//             offered word stable across decode stalls via a hold buffer, and
//             squashes the in-flight word on redirects.
//  Revision : 1.0 - initial release
// ============================================================================
module fetch_pc_unit #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        stall,
   input  logic        redirect,
   input  logic [31:0] redirect_target,
   output logic [31:0] imem_address,
   input  logic [31:0] imem_instruction,
   output logic [31:0] fetch_instruction,
   output logic [31:0] fetch_pc,
   output logic [31:0] fetch_pc_plus4,
   output logic        fetch_valid,
   output logic        redirect_misaligned
);

   localparam logic [31:0] c_PC_STEP = 32'd4;

   // Address currently presented to instruction memory.
   logic [31:0] r_pc;
   // PC of the word whose read data is (or was) returned by memory.
   logic [31:0] r_inflight_pc;
   logic        r_inflight_valid;
   // Copy of the offered word, taken on the first stalled edge because the
   // memory re-reads r_pc during a stall and its data no longer matches.
   logic        r_hold_valid;
   logic [31:0] r_hold_instr;
   logic        r_misalign;

   // Redirect target forced to a word boundary; misalignment is flagged apart.
   logic [31:0] w_target_aligned;
   logic        w_target_misaligned;
   // A stall only needs to capture when a real word is offered and not yet held.
   logic        w_capture;

   assign w_target_aligned    = {redirect_target[31:2], 2'b00};
   assign w_target_misaligned = |redirect_target[1:0];
   assign w_capture           = r_inflight_valid && !r_hold_valid;

   // PC sequencing, squash on redirect, and the stall hold buffer.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_pc             <= RESET_PC;
         r_inflight_pc    <= RESET_PC;
         r_inflight_valid <= 1'b0;
         r_hold_valid     <= 1'b0;
         r_hold_instr     <= NOP_INSTR;
         r_misalign       <= 1'b0;
      end else begin
         // The misalignment flag is a single-cycle pulse.
         r_misalign <= 1'b0;
         if (redirect) begin
            // Redirect beats stall: the word in flight and any held word
            // belong to the wrong path, so both are dropped.
            r_pc             <= w_target_aligned;
            r_inflight_valid <= 1'b0;
            r_hold_valid     <= 1'b0;
            r_misalign       <= w_target_misaligned;
         end else if (stall) begin
            // PC and in-flight tag are frozen; memory keeps re-reading r_pc,
            // which is exactly the next word needed once the stall lifts.
            if (w_capture) begin
               r_hold_instr <= imem_instruction;
               r_hold_valid <= 1'b1;
            end
         end else begin
            r_inflight_pc    <= r_pc;
            r_pc             <= r_pc + c_PC_STEP;
            r_inflight_valid <= 1'b1;
            r_hold_valid     <= 1'b0;
         end
      end
   end

   assign imem_address        = {2'b00, r_pc[31:2]};
   assign fetch_valid         = r_inflight_valid;
   assign fetch_pc            = r_inflight_pc;
   assign fetch_pc_plus4      = r_inflight_pc + c_PC_STEP;
   assign redirect_misaligned = r_misalign;

   // Offered word: NOP when invalid, held copy during/after a stall, else live data.
   always_comb begin
      fetch_instruction = imem_instruction;
      if (!r_inflight_valid) begin
         fetch_instruction = NOP_INSTR;
      end else if (r_hold_valid) begin
         fetch_instruction = r_hold_instr;
      end
   end

endmodule
`default_nettype wire
